// File: rtl/digit_combiner.sv
// Sequential BCD-to-binary converter: accumulates NUM_DIGITS BCD digits MSD-first
// using acc*10 + digit, with a start/busy/done handshake and invalid-digit flag.
module digit_combiner #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned VAL_W      = 40
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [4*NUM_DIGITS-1:0] i_digits,
  input  logic                    i_sign,
  output logic [VAL_W-1:0]        o_value,
  output logic                    o_sign,
  output logic                    o_err,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int unsigned DIG_W = 4 * NUM_DIGITS;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic {IDLE, CONV} state_e;

  state_e             state_q;
  logic [DIG_W-1:0]   digits_q;
  logic               sign_q;
  logic               err_q;
  logic [VAL_W-1:0]   acc_q;
  logic [IDX_W-1:0]   idx_q;
  logic [VAL_W-1:0]   value_q;
  logic               out_sign_q;
  logic               out_err_q;
  logic               busy_q;
  logic               done_q;

  logic               bad_digit_c;
  logic [3:0]         digit_c;
  logic [VAL_W-1:0]   acc_next_c;

  // Any incoming digit above 9 marks the whole request invalid
  always_comb begin
    bad_digit_c = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (i_digits[4*i +: 4] > 4'd9) bad_digit_c = 1'b1;
    end
  end

  always_comb begin
    digit_c = 4'd0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) digit_c = digits_q[4*i +: 4];
    end
  end

  assign acc_next_c = (acc_q << 3) + (acc_q << 1) + VAL_W'(digit_c);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      digits_q   <= '0;
      sign_q     <= 1'b0;
      err_q      <= 1'b0;
      acc_q      <= '0;
      idx_q      <= '0;
      value_q    <= '0;
      out_sign_q <= 1'b0;
      out_err_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            digits_q <= i_digits;
            sign_q   <= i_sign;
            err_q    <= bad_digit_c;
            acc_q    <= '0;
            idx_q    <= IDX_W'(NUM_DIGITS - 1);
            busy_q   <= 1'b1;
            state_q  <= CONV;
          end
        end
        CONV: begin
          acc_q <= acc_next_c;
          idx_q <= idx_q - IDX_W'(1);
          if (idx_q == '0) begin
            value_q    <= err_q ? '0 : acc_next_c;
            out_err_q  <= err_q;
            // Negative zero and invalid requests report a positive sign
            out_sign_q <= sign_q & ~err_q & (|acc_next_c);
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_value = value_q;
  assign o_sign  = out_sign_q;
  assign o_err   = out_err_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule

// File: doc/digit_combiner.md
# digit_combiner

Sequential decimal-to-binary converter, the inverse of the calculator's binary-to-digit separation path. Takes six BCD digits plus a sign, accumulates them MSD-first with an iterative multiply-by-10-and-add, and returns a 40-bit magnitude with a start/busy/done handshake. It sits between a digit-wise entry front end and the 40-bit `calculate`/`state_controller` datapath.

## Interface

Parameters:
- `NUM_DIGITS`, default 6: number of BCD digits converted. Conversion latency equals this value.
- `VAL_W`, default 40: width of `o_value`, matching the calculator datapath.

Ports, clock and reset first:
- `i_clk` input 1: single clock. All state updates on the rising edge.
- `i_rst_n` input 1: asynchronous, active-low reset.
- `i_start` input 1: one-cycle conversion request. Sampled only in IDLE.
- `i_digits` input 4*NUM_DIGITS: BCD digits. `[3:0]` is units, `[7:4]` is tens, and so on up to `[23:20]` for hundred-thousands.
- `i_sign` input 1: 1 means negative.
- `o_value` output VAL_W: converted magnitude, zero-extended. Holds its value until the next completion.
- `o_sign` output 1: registered result sign.
- `o_err` output 1: the last request contained a digit greater than 9.
- `o_busy` output 1: conversion in progress.
- `o_done` output 1: one-cycle completion pulse.

## Operation

- FSM states are IDLE and CONV.
- IDLE with `i_start` high at a rising edge:
  - latch `i_digits` and `i_sign`;
  - clear the accumulator `acc` to 0;
  - set `idx` to NUM_DIGITS-1;
  - set the error flag if any latched digit exceeds 9;
  - go to CONV, with `o_busy` set to 1.
- IDLE with `i_start` low: no change.
- CONV, every edge:
  - `acc` ← (`acc`<<3) + (`acc`<<1) + digit[`idx`];
  - `idx` ← `idx` - 1.
  - Arithmetic is unsigned at full VAL_W width, with no overflow possible: 999999 < 2^20.
- CONV, on the edge that processes `idx` = 0:
  - `o_value` ← final `acc`, or 0 if the error flag is set;
  - `o_err` ← error flag;
  - `o_sign` ← latched sign, forced to 0 if the result is 0 or the error flag is set;
  - `o_done` ← 1, `o_busy` ← 0, state ← IDLE.
- `o_done` is cleared on the following edge unless it is set again.
- `i_start` while busy is ignored: it is not queued and has no effect on the running conversion.
- Changes to `i_digits` or `i_sign` during CONV have no effect, because the inputs are latched.
- Reset, whether idle or mid-conversion, takes effect asynchronously:
  - state goes to IDLE;
  - `acc`, `idx` and the latched inputs are cleared;
  - all outputs go to 0 (`o_value`=0, `o_sign`=0, `o_err`=0, `o_busy`=0, `o_done`=0).
  - An aborted conversion produces no `o_done`.

## Timing

- Let `i_start` be sampled at edge k.
- Edges k+1 … k+NUM_DIGITS process the digits, most-significant digit first.
- Results and `o_done` become visible after edge k+NUM_DIGITS, which is 6 cycles of latency by default.
- `o_busy` is high from after edge k until edge k+NUM_DIGITS.
- `o_done` is high for exactly one cycle, between edge k+6 and edge k+7.
- Back-to-back: `i_start` held high in the `o_done` cycle is accepted at edge k+7. Maximum throughput is one conversion per NUM_DIGITS+1 cycles.
- The `o_value`, `o_sign` and `o_err` outputs change only at reset or at completion edges.
- Reset deassertion is assumed to be synchronised externally. The block has no internal reset synchroniser.

## Test plan

- **Reset values:** assert `i_rst_n`=0 mid-simulation → all outputs are 0 immediately, without waiting for a clock edge. After release, `o_busy`=0.
- **Basic conversion:** `i_digits`=24'h123456, `i_sign`=0, pulse `i_start` → `o_busy` high for 6 cycles. Then `o_done` is a single pulse with `o_value`=40'd123456, `o_sign`=0, `o_err`=0.
- **Extremes:**
  - 24'h999999 with `i_sign`=1 → `o_value`=999999, `o_sign`=1.
  - 24'h000000 with `i_sign`=1 → `o_value`=0, `o_sign`=0 (negative zero is suppressed).
- **Invalid digit:** `i_digits`=24'h12A456 → `o_done` after 6 cycles, with `o_err`=1, `o_value`=0, `o_sign`=0. A following valid request for 24'h000042 gives `o_err`=0 and `o_value`=42.
- **Handshake edges:**
  - Start a conversion of 24'h000777. Pulse `i_start` again, and change `i_digits` to 24'h111111, at cycle 3 → the result is 777 with only one `o_done` pulse.
  - Hold `i_start` high continuously → `o_done` pulses every 7 cycles.
- **Reset mid-conversion:** pulse `i_rst_n` low at cycle 3 of a conversion → no `o_done`, `o_value` stays 0. A fresh start afterwards converts correctly.
